// File: rtl/plab4_net_router_adaptive_term_ctrl_wh.sv
// Wormhole route/arbitration request control for a ring router terminal input port.
// Optional adaptive non-minimal routing is enabled by defining PLAB4_NET_TERM_CTRL_ADAPTIVE_EN.
module plab4_net_router_adaptive_term_ctrl_wh #(
    parameter int p_router_id      = 0,
    parameter int p_num_routers    = 8,
    parameter int p_num_free_nbits = 2,
    parameter int p_bubble         = 2,
    parameter int p_starve_max     = 15,
    localparam int c_dest_nbits    = $clog2(p_num_routers)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [c_dest_nbits-1:0]     dest,
    input  logic                        in_head,
    input  logic                        in_tail,
    input  logic                        in_val,
    output logic                        in_rdy,
    input  logic [p_num_free_nbits-1:0] num_free0,
    input  logic [p_num_free_nbits-1:0] num_free2,
    input  logic [p_num_free_nbits-1:0] num_free_chan0,
    input  logic [p_num_free_nbits-1:0] num_free_chan2,
    output logic [2:0]                  reqs,
    input  logic [2:0]                  grants,
    output logic                        locked,
    output logic                        starved
);

    localparam int c_cnt_nbits = $clog2(p_starve_max + 1);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_e;

    state_e                 state_r;
    state_e                 state_next_s;
    logic [2:0]             port_r;
    logic [c_cnt_nbits-1:0] cnt_r;
    logic [2:0]             reqs_s;
    logic [2:0]             min_s;
    logic [2:0]             route_s;
    logic [31:0]            diff_s;
    logic [31:0]            fwd_s;
    logic [31:0]            bwd_s;
    logic                   xfer_s;
    logic                   head_xfer_s;
    logic                   starved_s;

    assign xfer_s      = in_val & (|(reqs_s & grants));
    assign head_xfer_s = (state_r == IDLE) & in_head & xfer_s;
    assign starved_s   = (32'(cnt_r) >= 32'(p_starve_max));

`ifndef PLAB4_NET_TERM_CTRL_ADAPTIVE_EN
    logic chan_unused_s;
    assign chan_unused_s = ^{num_free_chan0, num_free_chan2};
`endif

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Locked output port captured from the head flit's winning request
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            port_r <= 3'b000;
        end else if (head_xfer_s && !in_tail) begin
            port_r <= reqs_s;
        end else begin
            port_r <= port_r;
        end
    end

    // Saturating count of cycles a waiting head flit has gone ungranted
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_r <= '0;
        end else if (!in_val || head_xfer_s) begin
            cnt_r <= '0;
        end else if ((state_r == IDLE) && in_head && !starved_s) begin
            cnt_r <= cnt_r + c_cnt_nbits'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Next-state logic
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (head_xfer_s && !in_tail) state_next_s = LOCKED;
                else                         state_next_s = IDLE;
            end
            LOCKED: begin
                if (xfer_s && in_tail) state_next_s = IDLE;
                else                   state_next_s = LOCKED;
            end
            default: state_next_s = IDLE;
        endcase
    end

    // Ring distance and route choice for the current destination
    always_comb begin
        diff_s = 32'(dest) + 32'(p_num_routers) - 32'(p_router_id);
        fwd_s  = (diff_s >= 32'(p_num_routers)) ? diff_s - 32'(p_num_routers) : diff_s;
        bwd_s  = 32'(p_num_routers) - fwd_s;
        min_s  = 3'b100;
        if (fwd_s == 32'd0) begin
            min_s = 3'b010;
        end else if (fwd_s < bwd_s) begin
            min_s = 3'b100;
        end else if (bwd_s < fwd_s) begin
            min_s = 3'b001;
        end else begin
`ifdef PLAB4_NET_TERM_CTRL_ADAPTIVE_EN
            if (num_free_chan0 > num_free_chan2) min_s = 3'b001;
            else                                 min_s = 3'b100;
`else
            min_s = 3'b100;
`endif
        end
        route_s = min_s;
`ifdef PLAB4_NET_TERM_CTRL_ADAPTIVE_EN
        // Take the long way round only when the short way is fully congested
        if (!starved_s && (min_s == 3'b100) && (num_free_chan2 == {p_num_free_nbits{1'b0}})
            && (num_free_chan0 != {p_num_free_nbits{1'b0}})) begin
            route_s = 3'b001;
        end else if (!starved_s && (min_s == 3'b001) && (num_free_chan0 == {p_num_free_nbits{1'b0}})
            && (num_free_chan2 != {p_num_free_nbits{1'b0}})) begin
            route_s = 3'b100;
        end else begin
            route_s = min_s;
        end
`endif
    end

    // Output logic: requests gated by downstream space
    always_comb begin
        reqs_s = 3'b000;
        case (state_r)
            IDLE: begin
                if (in_val && in_head) begin
                    case (route_s)
                        3'b100:  reqs_s = (32'(num_free2) >= 32'(p_bubble)) ? 3'b100 : 3'b000;
                        3'b001:  reqs_s = (32'(num_free0) >= 32'(p_bubble)) ? 3'b001 : 3'b000;
                        3'b010:  reqs_s = 3'b010;
                        default: reqs_s = 3'b000;
                    endcase
                end else begin
                    reqs_s = 3'b000;
                end
            end
            LOCKED: begin
                if (in_val) begin
                    case (port_r)
                        3'b100:  reqs_s = (num_free2 != {p_num_free_nbits{1'b0}}) ? 3'b100 : 3'b000;
                        3'b001:  reqs_s = (num_free0 != {p_num_free_nbits{1'b0}}) ? 3'b001 : 3'b000;
                        3'b010:  reqs_s = 3'b010;
                        default: reqs_s = 3'b000;
                    endcase
                end else begin
                    reqs_s = 3'b000;
                end
            end
            default: reqs_s = 3'b000;
        endcase
    end

    assign reqs    = reqs_s;
    assign in_rdy  = xfer_s;
    assign locked  = (state_r == LOCKED);
    assign starved = starved_s;

endmodule

// File: tb/tb_plab4_net_router_adaptive_term_ctrl_wh.sv
// Self-checking bench: directed vectors plus randomized traffic against a packet-level reference model.
module tb_plab4_net_router_adaptive_term_ctrl_wh;

    localparam int N    = 8;
    localparam int ID   = 2;
    localparam int BUB  = 2;
    localparam int SMAX = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] dest;
    logic       in_head, in_tail, in_val, in_rdy;
    logic [1:0] num_free0, num_free2, num_free_chan0, num_free_chan2;
    logic [2:0] reqs, grants;
    logic       locked, starved;

    int checks = 0;
    int errors = 0;

    // Reference model: port of the open packet (0 = none) and cycles a head has waited
    logic [2:0] m_port;
    int         m_wait;
    logic [2:0] e_reqs;
    logic       e_rdy;

    plab4_net_router_adaptive_term_ctrl_wh #(
        .p_router_id(ID), .p_num_routers(N), .p_num_free_nbits(2),
        .p_bubble(BUB), .p_starve_max(SMAX)
    ) dut (
        .clk(clk), .reset(reset), .dest(dest), .in_head(in_head), .in_tail(in_tail),
        .in_val(in_val), .in_rdy(in_rdy), .num_free0(num_free0), .num_free2(num_free2),
        .num_free_chan0(num_free_chan0), .num_free_chan2(num_free_chan2),
        .reqs(reqs), .grants(grants), .locked(locked), .starved(starved)
    );

    always #5 clk = ~clk;

    function automatic logic [2:0] m_route();
        int fwd, bwd;
        logic [2:0] r;
        fwd = (int'(dest) - ID + N) % N;
        bwd = N - fwd;
        if (fwd == 0) return 3'b010;
        if (fwd < bwd)      r = 3'b100;
        else if (bwd < fwd) r = 3'b001;
`ifdef PLAB4_NET_TERM_CTRL_ADAPTIVE_EN
        else r = (num_free_chan0 > num_free_chan2) ? 3'b001 : 3'b100;
        if (m_wait < SMAX) begin
            if (r == 3'b100 && num_free_chan2 == 0 && num_free_chan0 != 0)      r = 3'b001;
            else if (r == 3'b001 && num_free_chan0 == 0 && num_free_chan2 != 0) r = 3'b100;
        end
`else
        else r = 3'b100;
`endif
        return r;
    endfunction

    function automatic logic [2:0] m_reqs();
        logic [2:0] r;
        if (!in_val) return 3'b000;
        if (m_port != 3'b000) begin
            if (m_port == 3'b100) return (num_free2 >= 1) ? 3'b100 : 3'b000;
            if (m_port == 3'b001) return (num_free0 >= 1) ? 3'b001 : 3'b000;
            return m_port;
        end
        if (!in_head) return 3'b000;
        r = m_route();
        if (r == 3'b100 && int'(num_free2) < BUB) return 3'b000;
        if (r == 3'b001 && int'(num_free0) < BUB) return 3'b000;
        return r;
    endfunction

    task automatic check(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic set_in(input logic v, input logic h, input logic t, input logic [2:0] d,
                          input logic [1:0] f0, input logic [1:0] f2, input logic [1:0] c0,
                          input logic [1:0] c2, input logic [2:0] g);
        in_val = v; in_head = h; in_tail = t; dest = d;
        num_free0 = f0; num_free2 = f2; num_free_chan0 = c0; num_free_chan2 = c2; grants = g;
    endtask

    // Settle, then compare every output against the model
    task automatic eval(input string tag);
        #3;
        e_reqs = m_reqs();
        e_rdy  = in_val & (|(e_reqs & grants));
        check({tag, "_reqs"}, reqs, e_reqs);
        check({tag, "_rdy"}, {2'b00, in_rdy}, {2'b00, e_rdy});
        check({tag, "_locked"}, {2'b00, locked}, {2'b00, (m_port != 3'b000)});
        check({tag, "_starved"}, {2'b00, starved}, {2'b00, (m_wait >= SMAX)});
    endtask

    // Clock edge and model update from this cycle's inputs
    task automatic tick();
        @(posedge clk);
        if (m_port == 3'b000) begin
            if (in_val && in_head) begin
                if (e_rdy) begin
                    m_wait = 0;
                    if (!in_tail) m_port = e_reqs;
                end else if (m_wait < SMAX) begin
                    m_wait++;
                end
            end
        end else if (e_rdy && in_tail) begin
            m_port = 3'b000;
        end
        if (!in_val) m_wait = 0;
        #1;
    endtask

    initial begin
        m_port = 3'b000;
        m_wait = 0;
        reset  = 1'b1;
        set_in(1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 2'd0, 2'd0, 2'd0, 3'b000);
        #12;
        eval("reset");
        @(negedge clk) reset = 1'b0;
        @(posedge clk) #1;

        // Single-flit packet to the next router forward
        set_in(1'b1, 1'b1, 1'b1, 3'd3, 2'd0, 2'd2, 2'd1, 2'd1, 3'b100);
        eval("single"); check("single_const", reqs, 3'b100); tick();
        set_in(1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 2'd0, 2'd1, 2'd1, 3'b000);
        eval("single_after"); check("single_nolock", {2'b00, locked}, 3'b000); tick();

        // Four-flit wormhole packet, bodies with one free slot
        set_in(1'b1, 1'b1, 1'b0, 3'd5, 2'd0, 2'd2, 2'd1, 2'd1, 3'b100);
        eval("whead"); tick();
        for (int i = 0; i < 3; i++) begin
            set_in(1'b1, 1'b0, (i == 2), 3'd6, 2'd0, 2'd1, 2'd1, 2'd1, 3'b100);
            eval("wbody"); check("wbody_const", reqs, 3'b100);
            check("wbody_locked", {2'b00, locked}, 3'b001); tick();
        end
        set_in(1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 2'd1, 2'd1, 2'd1, 3'b000);
        eval("wdone"); check("wdone_unlocked", {2'b00, locked}, 3'b000); tick();

        // Bubble rule on the backward port
        set_in(1'b1, 1'b1, 1'b1, 3'd1, 2'd1, 2'd3, 2'd1, 2'd1, 3'b000);
        eval("bubble_lo"); check("bubble_lo_const", reqs, 3'b000); tick();
        set_in(1'b1, 1'b1, 1'b1, 3'd1, 2'd2, 2'd3, 2'd1, 2'd1, 3'b000);
        eval("bubble_ok"); check("bubble_ok_const", reqs, 3'b001); tick();
        set_in(1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 2'd0, 2'd0, 2'd0, 3'b000);
        eval("idle"); tick();

        // Congested minimal port, then starvation forcing minimal routing
        for (int i = 0; i < 3; i++) begin
            set_in(1'b1, 1'b1, 1'b1, 3'd5, 2'd2, 2'd2, 2'd2, 2'd0, 3'b000);
            eval("starve_wait");
`ifdef PLAB4_NET_TERM_CTRL_ADAPTIVE_EN
            check("adapt_const", reqs, 3'b001);
`else
            check("minimal_const", reqs, 3'b100);
`endif
            tick();
        end
        set_in(1'b1, 1'b1, 1'b1, 3'd5, 2'd2, 2'd2, 2'd2, 2'd0, 3'b100);
        eval("starved"); check("starved_const", {2'b00, starved}, 3'b001);
        check("starved_reqs_const", reqs, 3'b100); tick();
        set_in(1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 2'd0, 2'd0, 2'd0, 3'b000);
        eval("unstarved"); check("unstarved_const", {2'b00, starved}, 3'b000); tick();

        // Reset in the middle of a locked packet
        set_in(1'b1, 1'b1, 1'b0, 3'd5, 2'd0, 2'd2, 2'd1, 2'd1, 3'b100);
        eval("rhead"); tick();
        set_in(1'b1, 1'b0, 1'b0, 3'd5, 2'd0, 2'd2, 2'd1, 2'd1, 3'b100);
        #2 reset = 1'b1;
        #1 check("rst_locked_const", {2'b00, locked}, 3'b000);
        m_port = 3'b000; m_wait = 0;
        @(negedge clk) reset = 1'b0;
        @(posedge clk) #1;
        set_in(1'b1, 1'b0, 1'b0, 3'd5, 2'd0, 2'd2, 2'd1, 2'd1, 3'b100);
        eval("rbody"); check("rbody_const", reqs, 3'b000); tick();

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            logic [2:0] g;
            case ($urandom_range(3, 0))
                0: g = 3'b000;
                1: g = 3'b001;
                2: g = 3'b010;
                default: g = 3'b100;
            endcase
            set_in(($urandom_range(7, 0) != 0), ($urandom_range(2, 0) != 0), ($urandom_range(2, 0) == 0),
                   3'($urandom_range(7, 0)), 2'($urandom_range(3, 0)), 2'($urandom_range(3, 0)),
                   2'($urandom_range(3, 0)), 2'($urandom_range(3, 0)), g);
            eval("rand");
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/plab4_net_router_adaptive_term_ctrl_wh.md
PLAB4_NET_ROUTER_ADAPTIVE_TERM_CTRL_WH -- requirements
Module: plab4_net_router_adaptive_term_ctrl_wh

Interface
REQ-001 SHALL have parameter p_router_id, default 0, this router's ring position.
REQ-002 SHALL have parameter p_num_routers, default 8, ring size; c_dest_nbits = $clog2(p_num_routers).
REQ-003 SHALL have parameter p_num_free_nbits, default 2, width of all free-count inputs.
REQ-004 SHALL have parameter p_bubble, default 2, minimum downstream free entries needed to inject a head flit into the ring.
REQ-005 SHALL have parameter p_starve_max, default 15, starvation threshold in cycles (>=1).
REQ-006 SHALL have ports: clk in 1, reset in 1 (one clock; reset asynchronous, active-high).
REQ-007 SHALL have ports: dest in c_dest_nbits, destination of current flit's packet; in_head in 1; in_tail in 1.
REQ-008 SHALL have ports: in_val in 1; in_rdy out 1.
REQ-009 SHALL have ports: num_free0, num_free2 in p_num_free_nbits, downstream buffer space on ports 0/2.
REQ-010 SHALL have ports: num_free_chan0, num_free_chan2 in p_num_free_nbits, channel congestion estimate on ports 0/2.
REQ-011 SHALL have ports: reqs out 3 (bit0 backward, bit1 terminal, bit2 forward); grants in 3; locked out 1; starved out 1.

Function
REQ-012 SHALL compute fwd = (dest - p_router_id) mod p_num_routers, bwd = p_num_routers - fwd.
REQ-013 SHALL route dest == p_router_id to bit1; else minimal port is bit2 if fwd < bwd, bit0 if bwd < fwd.
REQ-014 SHALL, on tie (fwd == bwd), pick the port with larger num_free_chan; equal counts pick bit2.
REQ-015 SHALL, when adaptive (REQ-030), deviate to the non-minimal port iff minimal port's num_free_chan == 0, the other's is nonzero, and starved == 0.
REQ-016 SHALL in state IDLE, with in_val & in_head, assert the chosen reqs bit only if target num_free >= p_bubble (bit1: no check); else reqs = 0.
REQ-017 SHALL drive reqs = 0 whenever in_val == 0, and in IDLE whenever in_head == 0.
REQ-018 SHALL drive in_rdy = in_val & |(reqs & grants), combinationally; transfer = in_val & in_rdy.
REQ-019 SHALL, on a head transfer with in_tail == 0, register the granted port and enter LOCKED next cycle; head with in_tail == 1 stays IDLE.
REQ-020 SHALL in LOCKED assert only the locked port's reqs bit when in_val and that port's num_free >= 1 (bit1: no check), ignoring dest and in_head.
REQ-021 SHALL return to IDLE the cycle after a transfer with in_tail == 1 in LOCKED.
REQ-022 SHALL drive locked = 1 exactly in LOCKED.
REQ-023 SHALL increment a saturating starvation counter each IDLE cycle with in_val & in_head and no transfer; clear it on any head transfer or when in_val == 0.
REQ-024 SHALL drive starved = 1 while counter >= p_starve_max; starved forces minimal routing (REQ-015 disabled).
REQ-025 SHALL treat more than one grant bit set as impossible; only the bit matching reqs matters.

Reset
REQ-026 SHALL on reset enter IDLE, clear the locked port and the starvation counter, immediately and asynchronously.
REQ-027 SHALL during/after reset drive locked = 0, starved = 0; reqs and in_rdy follow IDLE rules.
REQ-028 SHALL abandon a partially sent packet on reset mid-LOCKED; next flit needs in_head to be routed.
REQ-029 SHALL hold no other state.

Configuration
REQ-030 SHALL with PLAB4_NET_TERM_CTRL_ADAPTIVE_EN defined apply REQ-014/REQ-015 deviation; undefined, route purely minimal (tie -> bit2), starvation counter still present, starved still output.

Verification (p_router_id=2, p_num_routers=8, nbits=2, p_bubble=2, p_starve_max=3)
REQ-031 Single-flit dest=3, free2=2, grants=100 -> reqs=100, in_rdy=1, locked stays 0.
REQ-032 Head dest=5 in_tail=0, grant 100; two bodies then tail with free2=1 -> reqs=100 each body, locked=1 until cycle after tail.
REQ-033 Head dest=1, free0=1 -> reqs=000 (bubble); free0=2 -> reqs=001.
REQ-034 ADAPTIVE_EN, head dest=5, chan2=0, chan0=2, free0=2 -> reqs=001; undefined -> reqs=100.
REQ-035 ADAPTIVE_EN, head dest=5, chan2=0, grants=000 for 3 cycles -> starved=1, reqs=100; after transfer starved=0.
REQ-036 Reset asserted mid-LOCKED -> locked=0 at once; next non-head flit gets reqs=000.
